fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single system clock; all logic rises on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port empty  input  1  FIFO empty flag from the demapped-byte FIFO.
REQ-005 SHALL have port data_in  input  8  FIFO read data, valid the cycle after a read_en cycle.
REQ-006 SHALL have port read_en  output  1  FIFO read strobe, one-cycle pulse per byte.
REQ-007 SHALL have port tx  output  1  serial line, idle high, 8N1 framing.
REQ-008 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 SHALL have port frame_cnt  output  8  count of completed frames, wraps.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, LATCH, START, DATA, STOP.
REQ-011 IDLE: if empty==0 at posedge -> FETCH; else stay IDLE.
REQ-012 FETCH: read_en=1 for exactly this one cycle; unconditionally -> LATCH.
REQ-013 LATCH: capture data_in into an 8-bit shift register at end of cycle; -> START.
REQ-014 read_en SHALL be 0 in every state other than FETCH; read_en is never asserted unless empty was 0 in the preceding IDLE cycle.
REQ-015 START: tx=0 for CLKS_PER_BIT cycles; -> DATA.
REQ-016 DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index; after bit 7 -> STOP.
REQ-017 STOP: tx=1 for CLKS_PER_BIT cycles; -> IDLE; frame_cnt increments by 1 on the final STOP cycle.
REQ-018 tx SHALL be 1 in IDLE, FETCH and LATCH, and SHALL be driven from a register (glitch-free).
REQ-019 Baud counter width SHALL be 16 bits; counts 0..CLKS_PER_BIT-1, resets to 0 on every state entry.
REQ-020 Latency: empty sampled 0 in IDLE at edge N -> read_en high in cycle N+1 -> tx falls at edge N+3.
REQ-021 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles from tx falling edge to end of stop bit.
REQ-022 Back-to-back: with FIFO non-empty, idle-high gap between consecutive stop bit end and next start bit SHALL be exactly 3 cycles (IDLE, FETCH, LATCH).
REQ-023 empty changes outside IDLE SHALL be ignored; the captured byte SHALL NOT change mid-frame.
REQ-024 frame_cnt SHALL wrap 255 -> 0 without any other side effect.
REQ-025 busy SHALL equal (state != IDLE), registered-decoded, no combinational path from empty.

Reset
REQ-026 Asserting reset SHALL immediately force state=IDLE, tx=1, read_en=0, busy=0, frame_cnt=0, baud counter=0, bit index=0, shift register=0.
REQ-027 Reset mid-frame SHALL abort the frame with no further read_en pulse and no frame_cnt increment; the partially sent byte is lost.
REQ-028 After reset deasserts, the first FSM transition SHALL occur no earlier than the first posedge clk with reset low.

Verification (CLKS_PER_BIT=4)
REQ-029 Single byte: FIFO holds 0xA5, empty falls -> one read_en pulse; tx = 0,1,0,1,0,0,1,0,1,1 each 4 cycles; frame_cnt 0->1; busy high for 43 cycles.
REQ-030 Back-to-back: FIFO holds 0x00,0xFF -> two read_en pulses 43 cycles apart; tx high exactly 3 cycles between frames; frame_cnt=2.
REQ-031 Empty FIFO: empty held 1 for 200 cycles -> read_en never asserted, tx=1, busy=0.
REQ-032 Reset mid-frame: assert reset during DATA bit 3 -> tx=1 and busy=0 same cycle; frame_cnt=0; on release with FIFO non-empty, new frame starts 3 cycles after first sampling edge.
REQ-033 Wrap: send 256 bytes -> frame_cnt returns to 0; exactly 256 read_en pulses counted.
REQ-034 Empty toggling: empty pulses 0 then 1 during STOP of a frame -> no extra read_en; next fetch only after IDLE samples empty==0.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Byte-at-a-time 8N1 serial transmitter that pulls bytes from a show-ahead-less FIFO.
// The line register follows the FSM state one cycle later, so the IDLE/FETCH/LATCH gap shows as exactly three high cycles.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       empty,
    input  logic [7:0] data_in,
    output logic       read_en,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_r;
    logic [15:0] baud_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift_r;
    logic        tx_r;
    logic        read_en_r;
    logic        busy_r;
    logic [7:0]  frame_cnt_r;
    logic        baud_done_s;

    assign baud_done_s = (baud_r == BAUD_LAST);

    // Transmit FSM with every output registered; busy also covers the trailing stop-bit cycle on the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            tx_r        <= 1'b1;
            read_en_r   <= 1'b0;
            busy_r      <= 1'b0;
            frame_cnt_r <= 8'd0;
            baud_r      <= 16'd0;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r      <= 1'b1;
                    baud_r    <= 16'd0;
                    bit_idx_r <= 3'd0;
                    if (!empty) begin
                        state_r   <= FETCH;
                        read_en_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        read_en_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                FETCH: begin
                    tx_r      <= 1'b1;
                    read_en_r <= 1'b0;
                    busy_r    <= 1'b1;
                    baud_r    <= 16'd0;
                    state_r   <= LATCH;
                end
                LATCH: begin
                    tx_r      <= 1'b1;
                    read_en_r <= 1'b0;
                    busy_r    <= 1'b1;
                    shift_r   <= data_in;
                    baud_r    <= 16'd0;
                    bit_idx_r <= 3'd0;
                    state_r   <= START;
                end
                START: begin
                    tx_r      <= 1'b0;
                    read_en_r <= 1'b0;
                    busy_r    <= 1'b1;
                    if (baud_done_s) begin
                        baud_r  <= 16'd0;
                        state_r <= DATA;
                    end else begin
                        baud_r  <= baud_r + 16'd1;
                        state_r <= START;
                    end
                end
                DATA: begin
                    // Index rather than shift so the captured byte stays intact for the whole frame.
                    tx_r      <= shift_r[bit_idx_r];
                    read_en_r <= 1'b0;
                    busy_r    <= 1'b1;
                    if (baud_done_s) begin
                        baud_r <= 16'd0;
                        if (bit_idx_r == 3'd7) begin
                            bit_idx_r <= 3'd0;
                            state_r   <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            state_r   <= DATA;
                        end
                    end else begin
                        baud_r  <= baud_r + 16'd1;
                        state_r <= DATA;
                    end
                end
                STOP: begin
                    tx_r      <= 1'b1;
                    read_en_r <= 1'b0;
                    busy_r    <= 1'b1;
                    if (baud_done_s) begin
                        baud_r      <= 16'd0;
                        frame_cnt_r <= frame_cnt_r + 8'd1;
                        state_r     <= IDLE;
                    end else begin
                        baud_r  <= baud_r + 16'd1;
                        state_r <= STOP;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    tx_r      <= 1'b1;
                    read_en_r <= 1'b0;
                    busy_r    <= 1'b0;
                    baud_r    <= 16'd0;
                    bit_idx_r <= 3'd0;
                end
            endcase
        end
    end

    assign tx        = tx_r;
    assign read_en   = read_en_r;
    assign busy      = busy_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx at CLKS_PER_BIT=4: a FIFO model feeds bytes, a line monitor decodes frames.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       empty = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       read_en;
    logic       tx;
    logic       busy;
    logic [7:0] frame_cnt;

    fifo_uart_tx #(.CLKS_PER_BIT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .empty    (empty),
        .data_in  (data_in),
        .read_en  (read_en),
        .tx       (tx),
        .busy     (busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         re_times[$];
    int         falls[$];
    logic       empty_force0 = 1'b0;

    int          cyc = 0;
    int          re_cnt = 0;
    int          busy_cnt = 0;
    int          tx_low_cnt = 0;
    int          frames_done = 0;
    int          underflow = 0;
    int          exp_fc = 0;
    int          fcnt = 0;
    logic        in_frame = 1'b0;
    logic        prev_tx = 1'b1;
    logic [39:0] pat = 40'd0;
    logic [39:0] ep;
    logic [9:0]  fb;
    logic [7:0]  eb;
    logic [7:0]  gb;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO model and line monitor: pops on read_en, decodes each 40-cycle frame against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (in_frame && exp_q.size() > 0) void'(exp_q.pop_front());
            in_frame = 1'b0;
            exp_fc   = 0;
            prev_tx  = tx;
        end else begin
            if (read_en) begin
                re_cnt++;
                re_times.push_back(cyc);
                if (fifo_q.size() > 0) data_in = fifo_q.pop_front();
                else begin
                    underflow++;
                    data_in = 8'hEE;
                end
            end
            if (busy) busy_cnt++;
            if (tx == 1'b0) tx_low_cnt++;
            if (!in_frame && tx == 1'b0 && prev_tx == 1'b1) begin
                in_frame = 1'b1;
                fcnt     = 0;
                falls.push_back(cyc);
            end
            if (in_frame) begin
                pat[fcnt] = tx;
                if (fcnt == 39) begin
                    if (exp_q.size() == 0) begin
                        check_val("extra_frame", 64'd1, 64'd0);
                        eb = 8'd0;
                    end else eb = exp_q.pop_front();
                    fb = {1'b1, eb, 1'b0};
                    for (int j = 0; j < 40; j++) ep[j] = fb[j/4];
                    for (int k = 0; k < 8; k++) gb[k] = pat[4*k+6];
                    check_val("frame_byte", 64'(gb), 64'(eb));
                    check_val("frame_wave", 64'(pat), 64'(ep));
                    exp_fc = (exp_fc + 1) % 256;
                    check_val("frame_cnt", 64'(frame_cnt), 64'(exp_fc));
                    frames_done++;
                    in_frame = 1'b0;
                end else fcnt++;
            end
            prev_tx = tx;
        end
        empty = (empty_force0 || fifo_q.size() != 0) ? 1'b0 : 1'b1;
    end

    task automatic do_reset();
        reset = 1'b1;
        empty_force0 = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (frames_done < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (frames_done < n) check_val("timeout_frames", 64'(frames_done), 64'(n));
    endtask

    task automatic wait_fall(input int n, input int budget);
        int t = 0;
        while (falls.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (falls.size() < n) check_val("timeout_fall", 64'(falls.size()), 64'(n));
    endtask

    task automatic send(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    initial begin
        int b_re, b_busy, b_low, b_ri, b_fi, b_fd, rel;

        @(negedge clk);
        check_val("rst_tx", 64'(tx), 64'd1);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_read_en", 64'(read_en), 64'd0);
        check_val("rst_frame_cnt", 64'(frame_cnt), 64'd0);

        // single byte 0xA5
        do_reset();
        b_re = re_cnt; b_busy = busy_cnt; b_ri = re_times.size(); b_fi = falls.size(); b_fd = frames_done;
        send(8'hA5);
        wait_frames(b_fd + 1, 200);
        repeat (10) @(negedge clk);
        check_val("a5_read_en_pulses", 64'(re_cnt - b_re), 64'd1);
        check_val("a5_busy_cycles", 64'(busy_cnt - b_busy), 64'd43);
        check_val("a5_latency", 64'(falls[b_fi] - re_times[b_ri]), 64'd3);
        check_val("a5_frame_cnt", 64'(frame_cnt), 64'd1);

        // back-to-back 0x00, 0xFF
        do_reset();
        b_re = re_cnt; b_ri = re_times.size(); b_fi = falls.size(); b_fd = frames_done;
        send(8'h00);
        send(8'hFF);
        wait_frames(b_fd + 2, 300);
        repeat (10) @(negedge clk);
        check_val("b2b_pulses", 64'(re_cnt - b_re), 64'd2);
        check_val("b2b_read_spacing", 64'(re_times[b_ri+1] - re_times[b_ri]), 64'd43);
        check_val("b2b_idle_gap", 64'(falls[b_fi+1] - falls[b_fi] - 40), 64'd3);
        check_val("b2b_frame_cnt", 64'(frame_cnt), 64'd2);

        // empty FIFO held for 200 cycles
        do_reset();
        b_re = re_cnt; b_busy = busy_cnt; b_low = tx_low_cnt;
        repeat (200) @(negedge clk);
        check_val("empty_read_en", 64'(re_cnt - b_re), 64'd0);
        check_val("empty_busy", 64'(busy_cnt - b_busy), 64'd0);
        check_val("empty_tx_low", 64'(tx_low_cnt - b_low), 64'd0);

        // reset during data bit 3 (0xA2 has bit 3 = 0, so tx is low there)
        do_reset();
        b_fi = falls.size();
        send(8'hA2);
        wait_fall(b_fi + 1, 50);
        repeat (17) @(negedge clk);
        check_val("pre_abort_tx", 64'(tx), 64'd0);
        reset = 1'b1;
        #1;
        check_val("abort_tx", 64'(tx), 64'd1);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_read_en", 64'(read_en), 64'd0);
        check_val("abort_frame_cnt", 64'(frame_cnt), 64'd0);
        send(8'h6B);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        rel = cyc; b_ri = re_times.size(); b_fi = falls.size(); b_fd = frames_done;
        wait_frames(b_fd + 1, 100);
        check_val("rel_read_en_cycle", 64'(re_times[b_ri] - rel), 64'd2);
        check_val("rel_latency", 64'(falls[b_fi] - re_times[b_ri]), 64'd3);
        check_val("rel_frame_cnt", 64'(frame_cnt), 64'd1);

        // empty pulses low during STOP only
        do_reset();
        b_re = re_cnt; b_ri = re_times.size(); b_fi = falls.size(); b_fd = frames_done;
        send(8'h5A);
        wait_fall(b_fi + 1, 50);
        repeat (36) @(negedge clk);
        empty_force0 = 1'b1;
        @(negedge clk);
        empty_force0 = 1'b0;
        wait_frames(b_fd + 1, 100);
        repeat (60) @(negedge clk);
        check_val("toggle_no_fetch", 64'(re_cnt - b_re), 64'd1);
        send(8'h11);
        wait_frames(b_fd + 2, 100);
        check_val("toggle_refetch", 64'(re_cnt - b_re), 64'd2);
        check_val("toggle_after_idle", 64'(re_times[b_ri+1] > falls[b_fi] + 40), 64'd1);

        // 256 frames wrap the counter back to zero
        do_reset();
        b_re = re_cnt; b_fd = frames_done;
        for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5C);
        wait_frames(b_fd + 256, 12000);
        repeat (10) @(negedge clk);
        check_val("wrap_frame_cnt", 64'(frame_cnt), 64'd0);
        check_val("wrap_pulses", 64'(re_cnt - b_re), 64'd256);
        check_val("fifo_underflow", 64'(underflow), 64'd0);
        check_val("scoreboard_left", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
